// File: rtl/crc_pkg.sv
// Shared constants, drain FSM state type and bit-twiddling helpers for the
// CRC result serializer.
package crc_pkg;

  localparam int          CRC_WIDTH   = 32;
  localparam logic [31:0] CRC32_POLY  = 32'h04C11DB7;
  localparam logic [31:0] XOR_OUT_DEF = 32'hFFFFFFFF;
  localparam int          MAX_W       = 64;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } drain_state_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MAX_W-1:0] reflect(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

  function automatic int lowest_set_idx(input logic [MAX_W-1:0] m);
    int idx;
    idx = 0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (m[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/crc_bundle_fifo.sv
// Synchronous FIFO holding whole result bundles; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module crc_bundle_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wr_en, rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end

endmodule

// File: rtl/crc_result_serializer.sv
// Finalises LANE_NUM raw CRCs per cycle (reflect + XOR, optional FCS compare),
// queues them as bundles and streams them out one lane per beat.
module crc_result_serializer
  import crc_pkg::*;
#(
  parameter int                   LANE_NUM    = 8,
  parameter int                   CRC_WIDTH   = crc_pkg::CRC_WIDTH,
  parameter int                   FIFO_DEPTH  = 16,
  parameter bit                   REFLECT_OUT = 1'b1,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT     = CRC_WIDTH'(XOR_OUT_DEF),
  parameter int                   LANE_W      = (LANE_NUM > 1) ? $clog2(LANE_NUM) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LANE_NUM-1:0]           lane_en,
  input  logic [LANE_NUM*CRC_WIDTH-1:0] lane_crc,
  input  logic [LANE_NUM*CRC_WIDTH-1:0] lane_fcs,
  input  logic                          check_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CRC_WIDTH-1:0]          out_crc,
  output logic [LANE_W-1:0]             out_lane,
  output logic                          out_match,
  output logic                          overflow,
  output logic [15:0]                   drop_cnt
);

  localparam int FW = LANE_NUM * CRC_WIDTH;
  localparam int BW = LANE_NUM * (CRC_WIDTH + 1) + LANE_NUM;

  logic [FW-1:0]       fin_c, s1_fin, hold_fin, hold_fin_nx, fifo_fin;
  logic [LANE_NUM-1:0] match_c, s1_match, s1_mask;
  logic [LANE_NUM-1:0] hold_mask, hold_mask_nx, hold_match, hold_match_nx;
  logic [LANE_NUM-1:0] fifo_mask, fifo_match, rest_mask;
  logic [BW-1:0]       fifo_dout;
  logic                push_req, pop, drop, fifo_full, fifo_empty;
  logic [LANE_W-1:0]   cur_idx;
  drain_state_t        state, state_nx;

  // Stage 1: finalise every lane, regardless of lane_en, and register.
  always_comb begin
    fin_c   = '0;
    match_c = '0;
    for (int i = 0; i < LANE_NUM; i++) begin
      logic [CRC_WIDTH-1:0] raw, f;
      raw = lane_crc[i*CRC_WIDTH +: CRC_WIDTH];
      f   = (REFLECT_OUT ? CRC_WIDTH'(reflect(MAX_W'(raw), CRC_WIDTH)) : raw) ^ XOR_OUT;
      fin_c[i*CRC_WIDTH +: CRC_WIDTH] = f;
      match_c[i] = check_mode & (f == lane_fcs[i*CRC_WIDTH +: CRC_WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_fin   <= '0;
      s1_match <= '0;
      s1_mask  <= '0;
    end else begin
      s1_fin   <= fin_c;
      s1_match <= match_c;
      s1_mask  <= lane_en;
    end
  end

  // A bundle is lost only when the FIFO is full and nothing leaves this edge.
  assign push_req = |s1_mask;
  assign drop     = push_req & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  crc_bundle_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   ({s1_mask, s1_fin, s1_match}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {fifo_mask, fifo_fin, fifo_match} = fifo_dout;

  assign cur_idx   = LANE_W'(lowest_set_idx(MAX_W'(hold_mask)));
  assign rest_mask = hold_mask & ~(LANE_NUM'(1) << cur_idx);

  // Drain FSM: state register (also owns the holding register).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      hold_mask  <= '0;
      hold_fin   <= '0;
      hold_match <= '0;
    end else begin
      state      <= state_nx;
      hold_mask  <= hold_mask_nx;
      hold_fin   <= hold_fin_nx;
      hold_match <= hold_match_nx;
    end
  end

  // Drain FSM: next state; the last beat of a bundle reloads without a bubble.
  always_comb begin
    state_nx      = state;
    hold_mask_nx  = hold_mask;
    hold_fin_nx   = hold_fin;
    hold_match_nx = hold_match;
    pop           = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          hold_mask_nx  = fifo_mask;
          hold_fin_nx   = fifo_fin;
          hold_match_nx = fifo_match;
          state_nx      = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          hold_mask_nx = rest_mask;
          if (rest_mask == '0) begin
            if (!fifo_empty) begin
              pop           = 1'b1;
              hold_mask_nx  = fifo_mask;
              hold_fin_nx   = fifo_fin;
              hold_match_nx = fifo_match;
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Drain FSM: outputs. Stream rule: a beat moves only when out_valid and
  // out_ready are both high; while stalled the beat comes purely from
  // registers and so cannot change.
  always_comb begin
    out_valid = 1'b0;
    out_crc   = '0;
    out_lane  = '0;
    out_match = 1'b0;
    if (state == S_SEND) begin
      out_valid = 1'b1;
      out_crc   = hold_fin[cur_idx*CRC_WIDTH +: CRC_WIDTH];
      out_lane  = cur_idx;
      out_match = hold_match[cur_idx];
    end
  end

endmodule

// File: tb/tb_crc_result_serializer.sv
// Directed bench for crc_result_serializer: latency, lane ordering,
// backpressure, overflow, FCS compare and mid-drain reset.
module tb_crc_result_serializer;

  localparam int LN = 8;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [LN-1:0]   lane_en;
  logic [LN*CW-1:0] lane_crc, lane_fcs;
  logic            check_mode;
  logic            out_valid, out_ready, out_match, overflow;
  logic [CW-1:0]   out_crc;
  logic [2:0]      out_lane;
  logic [15:0]     drop_cnt;

  int checks = 0;
  int passes = 0;
  logic [CW-1:0] exp_q[$];

  crc_result_serializer dut (
    .clk(clk), .rst(rst), .lane_en(lane_en), .lane_crc(lane_crc),
    .lane_fcs(lane_fcs), .check_mode(check_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_crc(out_crc), .out_lane(out_lane),
    .out_match(out_match), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference finalisation: bit-reverse then invert.
  function automatic logic [CW-1:0] fin_model(input logic [CW-1:0] x);
    logic [CW-1:0] r;
    for (int i = 0; i < CW; i++) r[CW-1-i] = x[i];
    return r ^ 32'hFFFFFFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_lane(input int i, input logic [CW-1:0] crc, input logic [CW-1:0] fcs);
    lane_crc[i*CW +: CW] = crc;
    lane_fcs[i*CW +: CW] = fcs;
  endtask

  task automatic check_beat(input string tag, input int lane, input logic [CW-1:0] crc);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lane"}, 32'(out_lane), 32'(lane));
    check({tag, "_crc"}, out_crc, crc);
  endtask

  initial begin
    logic [CW-1:0] c3, c4;
    rst = 1'b0; lane_en = '0; lane_crc = '0; lane_fcs = '0;
    check_mode = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_crc", out_crc, 32'd0);
    check("rst_lane", 32'(out_lane), 32'd0);
    check("rst_match", 32'(out_match), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // 1: single lane, N+3 latency, one beat
    lane_en = 8'h01; set_lane(0, 32'h2144DF1C, '0);
    tick(); lane_en = '0;
    check("s1_n1", 32'(out_valid), 32'd0);
    tick();
    check("s1_n2", 32'(out_valid), 32'd0);
    tick();
    check_beat("s1_beat", 0, 32'hC704DD7B);
    tick();
    check("s1_after", 32'(out_valid), 32'd0);

    // 2: multi-lane ordering
    for (int i = 0; i < LN; i++) set_lane(i, 32'h1000_0000 + 32'(i) * 32'h0101_0101, '0);
    lane_en = 8'hA5;
    tick(); lane_en = '0;
    tick(); tick();
    check_beat("s2_b0", 0, fin_model(32'h1000_0000));
    tick(); check_beat("s2_b1", 2, fin_model(32'h1202_0202));
    tick(); check_beat("s2_b2", 5, fin_model(32'h1505_0505));
    tick(); check_beat("s2_b3", 7, fin_model(32'h1707_0707));
    tick(); check("s2_end", 32'(out_valid), 32'd0);

    // 3: backpressure
    out_ready = 1'b0; lane_en = 8'hA5;
    tick(); lane_en = '0;
    tick(); tick();
    for (int k = 0; k < 10; k++) begin
      check_beat("s3_hold", 0, fin_model(32'h1000_0000));
      tick();
    end
    out_ready = 1'b1;
    check_beat("s3_b0", 0, fin_model(32'h1000_0000));
    tick(); check_beat("s3_b1", 2, fin_model(32'h1202_0202));
    tick(); check_beat("s3_b2", 5, fin_model(32'h1505_0505));
    tick(); check_beat("s3_b3", 7, fin_model(32'h1707_0707));
    tick(); check("s3_end", 32'(out_valid), 32'd0);

    // 4: overflow with 19 bundles against a stalled consumer
    out_ready = 1'b0;
    for (int b = 0; b < 19; b++) begin
      lane_en = 8'h01; set_lane(0, 32'hB000_0000 + 32'(b), '0);
      if (b < 17) exp_q.push_back(fin_model(32'hB000_0000 + 32'(b)));
      tick();
    end
    lane_en = '0;
    tick(); tick(); tick();
    check("s4_drop", 32'(drop_cnt), 32'd2);
    check("s4_ovf", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    for (int b = 0; b < 17; b++) begin
      logic [CW-1:0] e;
      e = exp_q.pop_front();
      check_beat("s4_drain", 0, e);
      tick();
    end
    check("s4_end", 32'(out_valid), 32'd0);
    check("s4_drop_kept", 32'(drop_cnt), 32'd2);

    // 5: FCS compare
    c3 = 32'hDEAD_BEEF; c4 = 32'h0BAD_F00D;
    check_mode = 1'b1; lane_en = 8'h18;
    set_lane(3, c3, fin_model(c3));
    set_lane(4, c4, fin_model(c4) ^ 32'h1);
    tick(); lane_en = '0; check_mode = 1'b0;
    tick(); tick();
    check_beat("s5_l3", 3, fin_model(c3));
    check("s5_m3", 32'(out_match), 32'd1);
    tick();
    check_beat("s5_l4", 4, fin_model(c4));
    check("s5_m4", 32'(out_match), 32'd0);
    set_lane(4, c4, fin_model(c4));
    lane_en = 8'h18;
    tick(); lane_en = '0;
    tick(); tick();
    check("s5_off_m3", 32'(out_match), 32'd0);
    tick();
    check("s5_off_m4", 32'(out_match), 32'd0);
    tick();
    check("s5_end", 32'(out_valid), 32'd0);

    // 6: reset while sending with two bundles queued
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      lane_en = 8'h01; set_lane(0, 32'hC000_0000 + 32'(b), '0);
      tick();
    end
    lane_en = '0;
    tick(); tick();
    check_beat("s6_pre", 0, fin_model(32'hC000_0000));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("s6_valid", 32'(out_valid), 32'd0);
    check("s6_ovf", 32'(overflow), 32'd0);
    check("s6_drop", 32'(drop_cnt), 32'd0);
    tick(); tick(); tick();
    check("s6_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    lane_en = 8'h01; set_lane(0, 32'h2144DF1C, '0);
    tick(); lane_en = '0;
    tick();
    check("s6_n2", 32'(out_valid), 32'd0);
    tick();
    check_beat("s6_beat", 0, 32'hC704DD7B);
    tick();
    check("s6_after", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
